// File: rtl/c432_resp_misr.sv
// Response compactor for the registered c432 harness: waits out the pipeline latency,
// folds N 7-bit responses into a Galois MISR, then compares the result to a golden signature.
module c432_resp_misr #(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = 16'h002D,
  parameter logic [SIG_W-1:0] SEED     = 16'h0000,
  parameter int               PIPE_LAT = 2,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] golden,
  input  logic [6:0]       resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pat_cnt
);

  typedef enum logic [1:0] {IDLE, FLUSH, COMPACT, DONE} state_t;

  localparam int FL_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int FL_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_d, gold_q, gold_d, misr_next;
  logic [CNT_W-1:0] cnt_d, num_q, num_d, cnt_inc;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic             busy_d, done_d, pass_d;

  assign misr_next = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(resp);
  assign cnt_inc   = pat_cnt + CNT_W'(1);

  // NOTE: every next-state variable is given its hold value first, so no path
  //       through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sig_d   = signature;
    cnt_d   = pat_cnt;
    num_d   = num_q;
    gold_d  = gold_q;
    flush_d = flush_q;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d   = num_patterns;
          gold_d  = golden;
          sig_d   = SEED;
          cnt_d   = '0;
          flush_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          if (num_patterns == '0) begin
            // Empty run: the seed itself is the final signature.
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (SEED == golden);
          end else begin
            state_d = (PIPE_LAT > 0) ? FLUSH : COMPACT;
            busy_d  = 1'b1;
          end
        end
      end

      FLUSH: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          flush_d = flush_q + FL_W'(1);
          if (flush_q == FL_W'(FL_LAST)) state_d = COMPACT;
        end
      end

      COMPACT: begin
        if (abort) begin
          // signature and pat_cnt are left as-is for post-mortem inspection.
          state_d = IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_next == gold_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  //       the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched run parameters are cleared too, so a reset leaves no
      //       stale golden/count from an interrupted run.
      state_q   <= IDLE;
      signature <= SEED;
      pat_cnt   <= '0;
      num_q     <= '0;
      gold_q    <= '0;
      flush_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      signature <= sig_d;
      pat_cnt   <= cnt_d;
      num_q     <= num_d;
      gold_q    <= gold_d;
      flush_q   <= flush_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

endmodule

// File: tb/tb_c432_resp_misr.sv
// Bench for c432_resp_misr: two instances (SEED=0/PIPE_LAT=2 and SEED=8000/PIPE_LAT=0)
// driven from a vector table, hand-written abort/reset sequences and random runs.
module tb_c432_resp_misr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [2];
  logic        abort_v [2];
  logic [15:0] num_v   [2];
  logic [15:0] gold_v  [2];
  logic [6:0]  resp_v  [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        pass_v  [2];
  logic [15:0] sig_v   [2];
  logic [15:0] cnt_v   [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] rbuf [64];

  always #5 clk = ~clk;

  c432_resp_misr #(.SIG_W(16), .POLY(16'h002D), .SEED(16'h0000), .PIPE_LAT(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
    .num_patterns(num_v[0]), .golden(gold_v[0]), .resp(resp_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .signature(sig_v[0]), .pat_cnt(cnt_v[0])
  );

  c432_resp_misr #(.SIG_W(16), .POLY(16'h002D), .SEED(16'h8000), .PIPE_LAT(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
    .num_patterns(num_v[1]), .golden(gold_v[1]), .resp(resp_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .signature(sig_v[1]), .pat_cnt(cnt_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] seed_of(input int d);
    return (d == 0) ? 16'h0000 : 16'h8000;
  endfunction

  // Signature as polynomial arithmetic: multiply by x, reduce modulo
  // x^16+x^5+x^3+x^2+1, then add in the response word.
  function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n);
    int unsigned v = seed;
    for (int i = 0; i < n; i++) begin
      v = v * 2;
      if (v >= 32'h10000) v = v ^ 32'h1002D;
      v = v ^ rbuf[i];
    end
    return 16'(v);
  endfunction

  // One complete run; responses are taken from rbuf[0..n-1]. A non-zero stray
  // cycle pulses start (with different parameters) while the run is busy.
  task automatic run(input int d, input int n, input logic [15:0] g,
                     input logic [15:0] exp_sig, input bit exp_pass,
                     input int stray, input string nm);
    int lat = (d == 0) ? 2 : 0;
    @(negedge clk);
    start_v[d] = 1'b1;
    num_v[d]   = 16'(n);
    gold_v[d]  = g;
    resp_v[d]  = 7'($urandom);
    @(negedge clk);
    start_v[d] = 1'b0;
    if (n == 0) begin
      check({nm, " n0 done"}, 32'(done_v[d]), 32'd1);
      check({nm, " n0 busy"}, 32'(busy_v[d]), 32'd0);
      check({nm, " n0 sig"},  32'(sig_v[d]),  32'(exp_sig));
      check({nm, " n0 pass"}, 32'(pass_v[d]), 32'(exp_pass));
      check({nm, " n0 cnt"},  32'(cnt_v[d]),  32'd0);
      return;
    end
    check({nm, " busy after start"}, 32'(busy_v[d]), 32'd1);
    check({nm, " done cleared"},     32'(done_v[d]), 32'd0);
    for (int c = 1; c <= lat + n; c++) begin
      resp_v[d] = (c > lat) ? rbuf[c - 1 - lat] : 7'($urandom);
      if (c == stray) begin
        start_v[d] = 1'b1;
        num_v[d]   = 16'($urandom_range(1, 5));
        gold_v[d]  = 16'($urandom);
      end else begin
        start_v[d] = 1'b0;
      end
      if (c == lat + n) check({nm, " done early"}, 32'(done_v[d]), 32'd0);
      @(negedge clk);
    end
    start_v[d] = 1'b0;
    check({nm, " done"}, 32'(done_v[d]), 32'd1);
    check({nm, " busy"}, 32'(busy_v[d]), 32'd0);
    check({nm, " sig"},  32'(sig_v[d]),  32'(exp_sig));
    check({nm, " pass"}, 32'(pass_v[d]), 32'(exp_pass));
    check({nm, " cnt"},  32'(cnt_v[d]),  32'(n));
  endtask

  typedef struct {
    int          d;
    int          n;
    logic [6:0]  r0;
    logic [6:0]  r1;
    logic [15:0] gold;
    logic [15:0] exp_sig;
    bit          exp_pass;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, 1, 7'h01, 7'h00, 16'h0001, 16'h0001, 1'b1};
    tbl[1] = '{0, 2, 7'h01, 7'h00, 16'h0002, 16'h0002, 1'b1};
    tbl[2] = '{0, 2, 7'h01, 7'h00, 16'h0003, 16'h0002, 1'b0};
    tbl[3] = '{1, 1, 7'h00, 7'h00, 16'h002D, 16'h002D, 1'b1};
    tbl[4] = '{0, 0, 7'h00, 7'h00, 16'h0000, 16'h0000, 1'b1};
    tbl[5] = '{1, 0, 7'h00, 7'h00, 16'h8000, 16'h8000, 1'b1};
    tbl[6] = '{1, 2, 7'h7F, 7'h01, 16'h00A5, 16'h00A5, 1'b1};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; abort_v[d] = 1'b0;
      num_v[d] = '0; gold_v[d] = '0; resp_v[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("reset sig",  32'(sig_v[d]),  32'(seed_of(d)));
      check("reset busy", 32'(busy_v[d]), 32'd0);
      check("reset done", 32'(done_v[d]), 32'd0);
      check("reset pass", 32'(pass_v[d]), 32'd0);
      check("reset cnt",  32'(cnt_v[d]),  32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      rbuf[0] = tbl[i].r0;
      rbuf[1] = tbl[i].r1;
      run(tbl[i].d, tbl[i].n, tbl[i].gold, tbl[i].exp_sig, tbl[i].exp_pass, 0,
          $sformatf("vec%0d", i));
    end

    // Abort during COMPACT once three responses have been folded in.
    for (int i = 0; i < 10; i++) rbuf[i] = 7'($urandom);
    @(negedge clk);
    start_v[0] = 1'b1; num_v[0] = 16'd10; gold_v[0] = 16'h1234;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      resp_v[0] = (c > 2) ? rbuf[c - 3] : 7'($urandom);
      @(negedge clk);
    end
    check("abort pre cnt", 32'(cnt_v[0]), 32'd3);
    abort_v[0] = 1'b1;
    resp_v[0]  = 7'h55;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check("abort busy", 32'(busy_v[0]), 32'd0);
    check("abort done", 32'(done_v[0]), 32'd0);
    check("abort pass", 32'(pass_v[0]), 32'd0);
    check("abort cnt",  32'(cnt_v[0]),  32'd3);
    check("abort sig",  32'(sig_v[0]),  32'(model_sig(16'h0000, 3)));
    repeat (3) @(negedge clk);
    check("abort idle hold", 32'(cnt_v[0]), 32'd3);
    for (int i = 0; i < 4; i++) rbuf[i] = 7'($urandom);
    run(0, 4, model_sig(16'h0000, 4), model_sig(16'h0000, 4), 1'b1, 0, "after abort");

    // Reset during FLUSH.
    @(negedge clk);
    start_v[0] = 1'b1; num_v[0] = 16'd5; gold_v[0] = 16'hBEEF;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("flush busy", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst sig",  32'(sig_v[0]),  32'h0000);
    check("rst busy", 32'(busy_v[0]), 32'd0);
    check("rst done", 32'(done_v[0]), 32'd0);
    check("rst pass", 32'(pass_v[0]), 32'd0);
    check("rst cnt",  32'(cnt_v[0]),  32'd0);
    check("rst sig1", 32'(sig_v[1]),  32'h8000);
    for (int i = 0; i < 3; i++) rbuf[i] = 7'($urandom);
    run(0, 3, 16'h0000, model_sig(16'h0000, 3), model_sig(16'h0000, 3) == 16'h0000, 0, "after rst");

    // Random runs, back to back (restart from DONE), one with a stray start.
    for (int i = 0; i < 16; i++) begin
      int          d = $urandom_range(0, 1);
      int          n = $urandom_range(1, 30);
      logic [15:0] e;
      logic [15:0] g;
      for (int k = 0; k < n; k++) rbuf[k] = 7'($urandom);
      e = model_sig(seed_of(d), n);
      g = ($urandom_range(0, 1) == 1) ? e : 16'($urandom);
      run(d, n, g, e, g == e, (i == 3 || i == 9) ? 1 : 0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
